// File: rtl/y86_pkg.sv
// ============================================================================
// Module : y86_pkg
// Desc   : Shared icode, register-specifier and status encodings for the
//          Y86-64 SEQ write-back stage.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RNONE   = 4'hF;
    localparam logic [3:0] RRSP    = 4'h4;

    localparam int NREGS = 15;

    typedef enum logic [2:0] {
        SAOK = 3'd1,
        SHLT = 3'd2,
        SINS = 3'd4
    } stat_t;

    function automatic logic icode_legal(input logic [3:0] ic);
        return (ic <= IPOPQ);
    endfunction

endpackage

`default_nettype wire

// File: rtl/y86_wb_dst.sv
// ============================================================================
// Module : y86_wb_dst
// Desc   : Combinational destination-register decode {icode,rA,rB,cnd} ->
//          {dstE,dstM}.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module y86_wb_dst
    import y86_pkg::*;
(
    input  logic [3:0] i_icode,
    input  logic [3:0] i_ra,
    input  logic [3:0] i_rb,
    input  logic       i_cnd,
    output logic [3:0] o_dst_e,
    output logic [3:0] o_dst_m
);

    always_comb begin
        o_dst_e = RNONE;
        case (i_icode)
            IRRMOVQ:                     o_dst_e = i_cnd ? i_rb : RNONE;
            IIRMOVQ, IOPQ:               o_dst_e = i_rb;
            ICALL, IRET, IPUSHQ, IPOPQ:  o_dst_e = RRSP;
            default:                     o_dst_e = RNONE;
        endcase
    end

    always_comb begin
        o_dst_m = RNONE;
        case (i_icode)
            IMRMOVQ, IPOPQ: o_dst_m = i_ra;
            default:        o_dst_m = RNONE;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/writeback_regfile.sv
// ============================================================================
// Module : writeback_regfile
// Desc   : Y86-64 SEQ write-back stage, register file, status and retired-
//          instruction counter. Optional same-cycle read bypass: WB_BYPASS_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module writeback_regfile
    import y86_pkg::*;
#(
    parameter logic [63:0] RSP_INIT = 64'h0,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    input  logic [3:0]       icode,
    input  logic [3:0]       rA,
    input  logic [3:0]       rB,
    input  logic             cnd,
    input  logic [63:0]      valE,
    input  logic [63:0]      valM,
    output logic [63:0]      value0,
    output logic [63:0]      value1,
    output logic [63:0]      value2,
    output logic [63:0]      value3,
    output logic [63:0]      value4,
    output logic [63:0]      value5,
    output logic [63:0]      value6,
    output logic [63:0]      value7,
    output logic [63:0]      value8,
    output logic [63:0]      value9,
    output logic [63:0]      value10,
    output logic [63:0]      value11,
    output logic [63:0]      value12,
    output logic [63:0]      value13,
    output logic [63:0]      value14,
    output logic [2:0]       stat,
    output logic [CNT_W-1:0] retire_cnt
`ifdef WB_BYPASS_EN
    ,
    input  logic [3:0]       srcA,
    input  logic [3:0]       srcB,
    output logic [63:0]      rdA,
    output logic [63:0]      rdB
`endif
);

    stat_t             r_state;
    stat_t             w_state_nxt;
    logic [63:0]       r_regs [NREGS];
    logic [CNT_W-1:0]  r_retire_cnt;

    logic [3:0]        w_dst_e;
    logic [3:0]        w_dst_m;
    logic              w_accept;
    logic              w_commit;
    logic              w_retire;

    y86_wb_dst u_dst (
        .i_icode (icode),
        .i_ra    (rA),
        .i_rb    (rB),
        .i_cnd   (cnd),
        .o_dst_e (w_dst_e),
        .o_dst_m (w_dst_m)
    );

    // Only a running core looks at its inputs; HLT/INS freeze everything.
    assign w_accept = (r_state == SAOK) && instr_valid;
    assign w_commit = w_accept && icode_legal(icode) && (icode != IHALT);
    assign w_retire = w_accept && icode_legal(icode);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SAOK;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SAOK: begin
                if (instr_valid) begin
                    if (icode == IHALT) begin
                        w_state_nxt = SHLT;
                    end else if (!icode_legal(icode)) begin
                        w_state_nxt = SINS;
                    end
                end
            end
            SHLT:    w_state_nxt = SHLT;
            SINS:    w_state_nxt = SINS;
            default: w_state_nxt = SINS;
        endcase
    end

    // M port is written after E so valM wins when both target the same reg.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= (4'(i) == RRSP) ? RSP_INIT : 64'h0;
            end
        end else if (w_commit) begin
            for (int i = 0; i < NREGS; i++) begin
                if (w_dst_e == 4'(i)) begin
                    r_regs[i] <= valE;
                end
                if (w_dst_m == 4'(i)) begin
                    r_regs[i] <= valM;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retire_cnt <= '0;
        end else if (w_retire) begin
            r_retire_cnt <= r_retire_cnt + CNT_W'(1);
        end
    end

    assign stat       = r_state;
    assign retire_cnt = r_retire_cnt;

    assign value0  = r_regs[0];
    assign value1  = r_regs[1];
    assign value2  = r_regs[2];
    assign value3  = r_regs[3];
    assign value4  = r_regs[4];
    assign value5  = r_regs[5];
    assign value6  = r_regs[6];
    assign value7  = r_regs[7];
    assign value8  = r_regs[8];
    assign value9  = r_regs[9];
    assign value10 = r_regs[10];
    assign value11 = r_regs[11];
    assign value12 = r_regs[12];
    assign value13 = r_regs[13];
    assign value14 = r_regs[14];

`ifdef WB_BYPASS_EN
    logic [63:0] w_rd_a;
    logic [63:0] w_rd_b;

    always_comb begin
        w_rd_a = 64'h0;
        for (int i = 0; i < NREGS; i++) begin
            if (srcA == 4'(i)) begin
                w_rd_a = r_regs[i];
            end
        end
        if (srcA != RNONE && w_commit) begin
            if (srcA == w_dst_m) begin
                w_rd_a = valM;
            end else if (srcA == w_dst_e) begin
                w_rd_a = valE;
            end
        end
    end

    always_comb begin
        w_rd_b = 64'h0;
        for (int i = 0; i < NREGS; i++) begin
            if (srcB == 4'(i)) begin
                w_rd_b = r_regs[i];
            end
        end
        if (srcB != RNONE && w_commit) begin
            if (srcB == w_dst_m) begin
                w_rd_b = valM;
            end else if (srcB == w_dst_e) begin
                w_rd_b = valE;
            end
        end
    end

    assign rdA = w_rd_a;
    assign rdB = w_rd_b;
`endif

endmodule

`default_nettype wire
